// File: rtl/lsu.sv
// Load/store unit: one transaction at a time, IDLE -> (REQ -> WAIT) -> DONE.
// Sub-word stores are lane-aligned with a byte mask; loads are realigned and extended on return.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  function automatic logic access_error(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = ld & st;
    case (f3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: bad = bad | off[0];
      3'b010:         bad = bad | (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] r;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'd0, s[7:0]};
      3'b101:  r = {16'd0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  state_t      state_q;
  logic        in_ready_q;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        mem_req_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_wen_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] mem_wdata_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic        out_err_q;

  logic        req_err_d;
  logic [3:0]  wmask_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;

  always_comb begin
    req_err_d = access_error(is_load, is_store, funct3, addr[1:0]);
    wmask_d   = is_store ? store_mask(funct3, addr[1:0]) : 4'b0000;
    wdata_d   = wdata << {addr[1:0], 3'b000};
    rdata_d   = load_q ? load_extract(f3_q, off_q, mem_rdata) : 32'd0;
  end

  // Every output is a register; a reset in any state drops the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      in_ready_q      <= 1'b1;
      load_q          <= 1'b0;
      f3_q            <= 3'b000;
      off_q           <= 2'b00;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wen_q       <= 1'b0;
      mem_wmask_q     <= 4'b0000;
      mem_wdata_q     <= 32'd0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'd0;
      out_err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            load_q     <= is_load;
            f3_q       <= funct3;
            off_q      <= addr[1:0];
            if (!is_load && !is_store) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= addr;
              out_err_q   <= 1'b0;
            end else if (req_err_d) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= 32'd0;
              out_err_q   <= 1'b1;
            end else begin
              state_q         <= S_REQ;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {addr[31:2], 2'b00};
              mem_wen_q       <= is_store;
              mem_wmask_q     <= wmask_d;
              mem_wdata_q     <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_WAIT;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_wmask_q     <= 4'b0000;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= rdata_d;
            out_err_q   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_wdata     = mem_wdata_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: queued expectations from an arithmetic model, a memory
// responder that checks requests, and an output monitor that checks results.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } out_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } req_t;

  out_t out_q[$];
  req_t req_q[$];

  int errors = 0;
  int checks = 0;

  int rdy_mode = 2;    // 0 random, 1 low, 2 high
  int or_mode  = 2;    // same encoding for out_ready
  int delay_fix = 0;   // -1 random response delay, otherwise fixed
  bit spur_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour from the access rules, in plain integer arithmetic.
  task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       output bit use_mem, output out_t o, output req_t r);
    int size;
    int off;
    longint v;
    logic [63:0] wide;
    int m;
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    use_mem = 0;
    o.data = 32'd0;
    o.err  = 1'b0;
    r.addr = a - 32'(off);
    r.wen = st;
    r.mask = 4'd0;
    r.wdata = 32'd0;
    r.rdata = rd;
    if (!ld && !st) begin
      o.data = a;
    end else if ((ld && st) || size == 0 || (off % size) != 0) begin
      o.err = 1'b1;
    end else begin
      use_mem = 1;
      if (st) begin
        m = ((1 << size) - 1) << off;
        r.mask = m[3:0];
        wide = {32'd0, wd} << (8 * off);
        r.wdata = wide[31:0];
      end else begin
        v = longint'(rd) >> (8 * off);
        if (size < 4) v = v % (64'sd1 << (8 * size));
        if (f3 < 3'd4 && size < 4 && v >= (64'sd1 << (8 * size - 1)))
          v = v - (64'sd1 << (8 * size));
        o.data = v[31:0];
      end
    end
  endtask

  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    bit um;
    out_t o;
    req_t r;
    int n;
    model(ld, st, f3, a, wd, rd, um, o, r);
    @(posedge clk); #1;
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    out_q.push_back(o);
    if (um) req_q.push_back(r);
    #1;
    in_valid = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((out_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(out_q.size() + req_q.size()), 32'd0);
  endtask

  // Memory responder: checks each accepted request, then answers after a delay.
  initial begin : memory
    bit pend = 0;
    int cnt = 0;
    logic [31:0] pend_data = 0;
    bit stall_prev = 0;
    logic [31:0] h_addr = 0, h_wdata = 0;
    logic h_wen = 0;
    logic [3:0] h_mask = 0;
    req_t r;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && stall_prev) begin
        chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
        chk("req_hold_addr", mem_addr, h_addr);
        chk("req_hold_wen", 32'(mem_wen), 32'(h_wen));
        chk("req_hold_mask", 32'(mem_wmask), 32'(h_mask));
        chk("req_hold_wdata", mem_wdata, h_wdata);
      end
      if (rst_n && mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'(mem_req_valid), 32'd0);
        end else begin
          r = req_q.pop_front();
          chk("req_addr", mem_addr, r.addr);
          chk("req_wen", 32'(mem_wen), 32'(r.wen));
          chk("req_mask", 32'(mem_wmask), 32'(r.mask));
          if (r.wen) chk("req_wdata", mem_wdata, r.wdata);
          pend = 1;
          cnt = (delay_fix < 0) ? int'($urandom_range(0, 2)) : delay_fix;
          pend_data = r.rdata;
        end
      end
      stall_prev = rst_n && mem_req_valid && !mem_req_ready;
      h_addr = mem_addr; h_wen = mem_wen; h_mask = mem_wmask; h_wdata = mem_wdata;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = pend_data;
          pend = 0;
        end else begin
          cnt--;
        end
      end else if (spur_en && ($urandom % 6) == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata = $urandom;
      end
      mem_req_ready = (rdy_mode == 0) ? 1'($urandom % 3 != 0) : (rdy_mode == 2);
    end
  end

  initial begin : out_ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (or_mode == 0) ? 1'($urandom % 2) : (or_mode == 2);
    end
  end

  // Output monitor: held results must not move, completions are checked in order.
  initial begin : monitor
    bit hold_prev = 0;
    logic [31:0] h_data = 0;
    logic h_err = 0;
    out_t o;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          chk("out_hold_valid", 32'(out_valid), 32'd1);
          chk("out_hold_data", out_data, h_data);
          chk("out_hold_err", 32'(out_err), 32'(h_err));
        end
        if (out_valid) chk("in_ready_while_done", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (out_q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            o = out_q.pop_front();
            chk("out_data", out_data, o.data);
            chk("out_err", 32'(out_err), 32'(o.err));
          end
        end
        hold_prev = out_valid && !out_ready;
        h_data = out_data;
        h_err = out_err;
      end
    end
  end

  initial begin : stimulus
    logic [2:0] ld_f3[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0] st_f3[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    in_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;

    // LB sign-extending, minimum latency with an immediate memory.
    rdy_mode = 2; delay_fix = 0; or_mode = 2;
    issue(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234);
    @(negedge clk);
    chk("lb_req_valid", 32'(mem_req_valid), 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk("lb_mem_wmask", 32'(mem_wmask), 32'd0);
    @(negedge clk);
    chk("lb_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lb_valid_n3", 32'(out_valid), 32'd1);
    chk("lb_data", out_data, 32'hFFFF_FF80);
    drain();

    // SH to the upper half-word.
    issue(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0);
    @(negedge clk);
    chk("sh_wen", 32'(mem_wen), 32'd1);
    chk("sh_mask", 32'(mem_wmask), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_0000);
    drain();

    // Misaligned LW errors out next cycle without touching memory.
    issue(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0);
    @(negedge clk);
    chk("lw_mis_valid", 32'(out_valid), 32'd1);
    chk("lw_mis_err", 32'(out_err), 32'd1);
    chk("lw_mis_no_req", 32'(mem_req_valid), 32'd0);
    drain();

    // Pass-through held under back-pressure for three cycles.
    or_mode = 1;
    issue(0, 0, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pt_valid_held", 32'(out_valid), 32'd1);
      chk("pt_data_held", out_data, 32'h1234_5678);
      chk("pt_in_ready_low", 32'(in_ready), 32'd0);
      if (k == 2) or_mode = 2;
    end
    @(negedge clk);
    chk("pt_released", 32'(out_valid), 32'd0);
    drain();

    // LHU with the memory stalling the request for two cycles.
    rdy_mode = 1;
    issue(1, 0, 3'b101, 32'h0000_0010, 32'h0, 32'h0000_8001);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lhu_stall_valid", 32'(mem_req_valid), 32'd1);
      chk("lhu_stall_addr", mem_addr, 32'h0000_0010);
    end
    rdy_mode = 2;
    drain();

    // Random traffic with stalls, delays, back-pressure and stray responses.
    rdy_mode = 0; or_mode = 0; delay_fix = -1; spur_en = 1;
    for (int i = 0; i < 150; i++) begin
      int c;
      bit ld, st;
      logic [2:0] f3;
      c = int'($urandom % 10);
      ld = (c >= 2 && c <= 5) || c == 1;
      st = (c >= 6) || c == 1;
      f3 = st ? st_f3[$urandom % 6] : ld_f3[$urandom % 8];
      issue(ld, st, f3, $urandom, $urandom, $urandom);
      if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();
    spur_en = 0;

    // Reset while waiting for a response; the late response must be dropped.
    rdy_mode = 2; or_mode = 2; delay_fix = 2;
    issue(1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rw_req_valid", 32'(mem_req_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    out_q.delete();
    req_q.delete();
    #1;
    chk("rw_rst_in_ready", 32'(in_ready), 32'd1);
    chk("rw_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rw_no_out", 32'(out_valid), 32'd0);
      chk("rw_in_ready", 32'(in_ready), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
